// File: rtl/twd_sched.sv
// Twiddle/butterfly stage scheduler: frames 16-sample blocks and strobes each stage.
// Define TWD_SCHED_ERR_EN to flag and resync on i_sof protocol errors.
module twd_sched #(
    parameter int BLK_PER_FRAME = 32,
    parameter int NUM_STG       = 3,
    parameter int STG_LAT       = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_valid,
    input  logic                                      i_sof,
    input  logic                                      i_hold,
    output logic                                      o_ready,
    output logic [NUM_STG-1:0]                        o_stg_valid,
    output logic [NUM_STG*$clog2(BLK_PER_FRAME)-1:0]  o_stg_cnt,
    output logic                                      o_sof,
    output logic                                      o_eof,
    output logic                                      o_busy,
    output logic                                      o_err
);
    localparam int CW    = $clog2(BLK_PER_FRAME);
    localparam int DEPTH = NUM_STG * STG_LAT;
    localparam int FW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLK_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_fcnt, w_fcnt_nx, w_inc, w_idx;
    logic [FW-1:0]   r_fl, w_fl_nx;
    logic [DEPTH-1:0] r_sv;
    logic [CW-1:0]   r_sc [DEPTH];
    logic            w_acc, w_push;
`ifdef TWD_SCHED_ERR_EN
    logic            r_err, w_err_set;
`endif

    assign o_ready = ~i_hold;
    assign w_acc   = i_valid & ~i_hold;
    assign w_inc   = (r_fcnt == LAST) ? '0 : r_fcnt + CW'(1);

    always_comb begin
        w_state_nx = r_state;
        w_fcnt_nx  = r_fcnt;
        w_fl_nx    = r_fl;
        w_push     = 1'b0;
        w_idx      = r_fcnt;
`ifdef TWD_SCHED_ERR_EN
        w_err_set  = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_acc && i_sof) begin
                    w_push     = 1'b1;
                    w_idx      = '0;
                    w_fcnt_nx  = CW'(1);
                    w_state_nx = RUN;
                end
`ifdef TWD_SCHED_ERR_EN
                else if (w_acc) w_err_set = 1'b1;
`endif
            end
            RUN: begin
                if (w_acc) begin
                    w_push    = 1'b1;
                    w_idx     = r_fcnt;
                    w_fcnt_nx = w_inc;
`ifdef TWD_SCHED_ERR_EN
                    if (i_sof && r_fcnt != '0) begin
                        w_err_set = 1'b1;
                        w_idx     = '0;
                        w_fcnt_nx = CW'(1);
                    end
`endif
                end else if (r_fcnt == '0) begin
                    // fcnt==0 in RUN only after a wrap: frame done, drain
                    w_state_nx = FLUSH;
                    w_fl_nx    = '0;
                end
            end
            FLUSH: begin
                if (w_acc && i_sof) begin
                    w_push     = 1'b1;
                    w_idx      = '0;
                    w_fcnt_nx  = CW'(1);
                    w_state_nx = RUN;
                end else begin
`ifdef TWD_SCHED_ERR_EN
                    if (w_acc) w_err_set = 1'b1;
`endif
                    if (r_fl == FW'(DEPTH - 1)) w_state_nx = IDLE;
                    else w_fl_nx = r_fl + FW'(1);
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_fcnt  <= '0;
            r_fl    <= '0;
        end else if (!i_hold) begin
            r_state <= w_state_nx;
            r_fcnt  <= w_fcnt_nx;
            r_fl    <= w_fl_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sv <= '0;
            for (int i = 0; i < DEPTH; i++) r_sc[i] <= '0;
        end else if (!i_hold) begin
            r_sv[0] <= w_push;
            r_sc[0] <= w_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_sv[i] <= r_sv[i-1];
                r_sc[i] <= r_sc[i-1];
            end
        end
    end

`ifdef TWD_SCHED_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else if (!i_hold && w_err_set) r_err <= 1'b1;
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
        assign o_stg_valid[k]          = r_sv[(k+1)*STG_LAT-1];
        assign o_stg_cnt[k*CW +: CW]   = r_sc[(k+1)*STG_LAT-1];
    end

    assign o_sof  = o_stg_valid[NUM_STG-1] &&
                    (o_stg_cnt[(NUM_STG-1)*CW +: CW] == '0);
    assign o_eof  = o_stg_valid[NUM_STG-1] &&
                    (o_stg_cnt[(NUM_STG-1)*CW +: CW] == LAST);
    assign o_busy = (r_state != IDLE);
endmodule
